uart_tx_driver: RTL and testbench
=================================

Name: uart_tx_driver

Overview:
- Synthesizable UART 8N1-style transmitter that drives the chip's uart_rx pin. It is the transmit counterpart of the bench's UART receiver model.
- Accepts bytes over a valid/ready push interface and buffers them in a small FIFO. Serialises each byte LSB-first with an optional even-parity bit, and honours the chip's active-low RTS as clear-to-send.
- Used in pulpino_top benches and in FPGA bring-up harnesses to inject console input.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock frequency.
- BAUD_RATE, 3125000, line rate. DIV = CLK_FREQ_HZ/BAUD_RATE, integer truncation; defaults give DIV = 32. DIV < 2 is an elaboration error.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, minimum 2.
- PARITY_EN, 0, 1 = insert even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- tx_data_i  in  8  byte to enqueue.
- tx_valid_i  in  1  push request.
- tx_ready_o  out  1  FIFO can accept; equals !full.
- cts_ni  in  1  active-low clear-to-send (wired to the chip's uart_rts).
- uart_tx_o  out  1  serial line; idles high.
- busy_o  out  1  high while a frame is on the line.
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values, applied at the first rising edge with rst = 1:
  - uart_tx_o = 1, busy_o = 0, fifo_count_o = 0, tx_ready_o = 1.
  - FSM = IDLE, bit counter = 0, baud counter = 0, FIFO pointers cleared.
- Push:
  - A byte is written on an edge where tx_valid_i && tx_ready_o.
  - tx_valid_i while full is ignored; no data is lost from the FIFO and nothing is overwritten.
  - A push while full is not accepted even if a pop occurs in the same cycle.
- FIFO:
  - Circular buffer with registered count.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE:
  - uart_tx_o = 1, busy_o = 0.
  - If count > 0 and cts_ni == 0 at an edge: pop the head into the shift register, go to START, and drive uart_tx_o = 0 from that edge.
  - A byte pushed at edge N therefore produces the start bit after edge N+1.
- Bit timing:
  - Every bit (start, data, parity, stop) is held exactly DIV cycles.
  - The baud counter counts 0..DIV-1 and resets on each state transition.
- START: after DIV cycles → DATA.
- DATA:
  - 8 bits, LSB first, each driven from shift_reg[0]; shift right at the end of each bit period.
  - After the 8th bit → PARITY if PARITY_EN, else STOP.
- PARITY: drives the XOR of the 8 data bits (even parity), then → STOP.
- STOP:
  - Drives 1 for STOP_BITS*DIV cycles.
  - On the final cycle, if count > 0 and cts_ni == 0, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length = (1 + 8 + PARITY_EN + STOP_BITS) * DIV cycles.
- busy_o is 1 in all states except IDLE.
- cts_ni is sampled only at frame-start decisions. A deassert mid-frame never truncates the current frame.
- Reset mid-frame: the line returns to 1 at the reset edge, the FIFO is flushed, and the partial frame is abandoned.
- Pop and push of the same entry: a push into an empty FIFO is not visible to the FSM until the following edge.

Test Plan:
- Defaults, push 0x65 with cts_ni = 0:
  - Start bit begins 1 cycle after the push edge.
  - Line bits per 32 cycles: 0, 1,0,1,0,0,1,1,0, 1.
  - busy_o high for exactly 320 cycles.
- Push 0x00, 0xFF, 0x55 back-to-back: 960 contiguous busy cycles, no idle cycle between stop and next start, all bytes decoded correctly by the bench UART receiver.
- cts_ni = 1, push 10 bytes on consecutive cycles:
  - First 8 accepted; tx_ready_o = 0 from the cycle after the 8th push; fifo_count_o = 8; uart_tx_o stays 1.
  - Releasing cts_ni sends exactly 8 bytes, in order.
- PARITY_EN = 1, STOP_BITS = 2, byte 0x07: parity bit = 1, two stop bits, frame = 384 cycles.
- Raise cts_ni during bit 3 of a frame: frame completes intact, next queued byte is held until cts_ni = 0.
- Assert rst for 1 cycle during data bit 5 with 3 bytes queued: uart_tx_o = 1 and fifo_count_o = 0 next cycle, no further frames emitted.

Source files
------------

// File: rtl/uart_tx_driver.sv
// UART transmitter that injects console bytes into the chip's uart_rx pin.
// Bytes are pushed over a valid/ready interface into a small circular FIFO,
// then serialised LSB-first with an optional even-parity bit and 1 or 2
// stop bits. A new frame only starts while the active-low cts_ni is low.
module uart_tx_driver #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 3125000,
  parameter int FIFO_DEPTH  = 8,
  parameter int PARITY_EN   = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           tx_data_i,
  input  logic                                 tx_valid_i,
  output logic                                 tx_ready_o,
  input  logic                                 cts_ni,
  output logic                                 uart_tx_o,
  output logic                                 busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_o
);

  localparam int DIV      = CLK_FREQ_HZ / BAUD_RATE;
  localparam int STOP_LEN = STOP_BITS * DIV;
  // The baud counter also times the whole stop period, so size it for that.
  localparam int BAUD_W   = $clog2(STOP_LEN);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(DIV - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  // Reject parameter sets the datapath cannot honour.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_driver: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_driver: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_driver: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [7:0]          head_data;
  logic                push;
  logic                pop;
  logic                start_ok;

  // Full is judged on the registered count, so a same-cycle pop never
  // frees a slot for a push arriving while full.
  assign push      = tx_valid_i && (count_q != FULL_CNT);
  assign head_data = fifo_mem[rd_ptr_q];
  // Only the registered count is visible here: a byte pushed into an empty
  // FIFO cannot be popped until the edge after it was written.
  assign start_ok  = (count_q != '0) && !cts_ni;

  // FIFO storage; contents are not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= tx_data_i;
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: next state, bit timing and the next line value.
  always_comb begin
    logic load;
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (start_ok) begin
          load = 1'b1;
        end
      end
      S_START: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          if (start_ok) begin
            // Back-to-back frames: no idle cycle between stop and start.
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      pop      = 1'b1;
      shift_d  = head_data;
      parity_d = ^head_data;
      bit_d    = 3'd0;
      state_d  = S_START;
      tx_d     = 1'b0;
    end
  end

  // busy reflects the state being entered so it stays aligned with the line.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous reset; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign tx_ready_o   = (count_q != FULL_CNT);
  assign uart_tx_o    = tx_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_driver.sv
// Directed bench for uart_tx_driver: dut0 uses defaults (8N1, DIV=32),
// dut1 adds even parity and two stop bits.
module tb_uart_tx_driver;

  localparam int DIV = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1;
  logic       v0, v1, c0, c1;
  logic       ready0, ready1, tx0, tx1, busy0, busy1;
  logic [3:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;
  int busy_total = 0;

  always #5 clk = ~clk;

  uart_tx_driver dut0 (
    .clk          (clk),
    .rst          (rst),
    .tx_data_i    (d0),
    .tx_valid_i   (v0),
    .tx_ready_o   (ready0),
    .cts_ni       (c0),
    .uart_tx_o    (tx0),
    .busy_o       (busy0),
    .fifo_count_o (cnt0)
  );

  uart_tx_driver #(.PARITY_EN(1), .STOP_BITS(2)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .tx_data_i    (d1),
    .tx_valid_i   (v1),
    .tx_ready_o   (ready1),
    .cts_ni       (c1),
    .uart_tx_o    (tx1),
    .busy_o       (busy1),
    .fifo_count_o (cnt1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 1) ? tx1 : tx0;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? busy1 : busy0;
  endfunction

  // Walks one frame cycle by cycle, starting on the first start-bit cycle.
  // Each bit window must hold its value for DIV cycles; mid-bit samples are
  // also decoded like a UART receiver. Leaves off on the cycle after the frame.
  task automatic check_frame(input int sel, input logic [7:0] data, input int par_en,
                             input int stop_bits, input int raise_at);
    logic exp_bits [12];
    logic rx_bits  [12];
    logic [7:0] rx_byte;
    int nbits;
    int busy_cnt;
    int bad;
    nbits = 1 + 8 + par_en + stop_bits;
    exp_bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) exp_bits[1+k] = data[k];
    if (par_en != 0) exp_bits[9] = ^data;
    for (int k = 9 + par_en; k < 12; k++) exp_bits[k] = 1'b1;
    busy_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        if (b * DIV + c == raise_at) c0 = 1'b1;
        if (line_of(sel) !== exp_bits[b]) bad++;
        if (c == DIV / 2) rx_bits[b] = line_of(sel);
        if (busy_of(sel) === 1'b1) busy_cnt++;
        tick();
      end
      check($sformatf("dut%0d byte %02h bit%0d bad cycles", sel, data, b), bad, 0);
    end
    for (int k = 0; k < 8; k++) rx_byte[k] = rx_bits[1+k];
    check($sformatf("dut%0d decoded byte", sel), {24'd0, rx_byte}, {24'd0, data});
    check($sformatf("dut%0d byte %02h busy cycles", sel, data), busy_cnt, nbits * DIV);
    busy_total += busy_cnt;
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    d0 = 8'h00; d1 = 8'h00;
    v0 = 1'b0;  v1 = 1'b0;
    c0 = 1'b0;  c1 = 1'b0;

    // Reset state
    tick();
    check("reset tx", tx0, 1);
    check("reset busy", busy0, 0);
    check("reset count", cnt0, 0);
    check("reset ready", ready0, 1);
    check("reset tx dut1", tx1, 1);
    rst = 1'b0;
    tick();

    // Single byte 0x65, start bit one cycle after the push edge
    d0 = 8'h65; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    check("push count", cnt0, 1);
    check("push tx still idle", tx0, 1);
    check("push busy still low", busy0, 0);
    tick();
    check_frame(0, 8'h65, 0, 1, -1);
    check("0x65 idle busy", busy0, 0);
    check("0x65 idle tx", tx0, 1);

    // Three back-to-back frames, no gap
    c0 = 1'b1;
    d0 = 8'h00; v0 = 1'b1; tick();
    d0 = 8'hFF; tick();
    d0 = 8'h55; tick();
    v0 = 1'b0;
    check("b2b count", cnt0, 3);
    c0 = 1'b0;
    tick();
    busy_total = 0;
    check_frame(0, 8'h00, 0, 1, -1);
    check_frame(0, 8'hFF, 0, 1, -1);
    check_frame(0, 8'h55, 0, 1, -1);
    check("b2b busy total", busy_total, 960);
    check("b2b idle after", busy0, 0);

    // Fill while CTS deasserted: 8 of 10 accepted, line stays idle
    c0 = 1'b1; v0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d0 = 8'(8'hA0 + i);
      tick();
      check($sformatf("fill ready after push %0d", i), ready0, (i < 7) ? 1 : 0);
      check($sformatf("fill count after push %0d", i), cnt0, (i < 7) ? i + 1 : 8);
    end
    v0 = 1'b0;
    repeat (20) tick();
    check("fill tx idle", tx0, 1);
    check("fill busy low", busy0, 0);
    check("fill count held", cnt0, 8);
    c0 = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) check_frame(0, 8'(8'hA0 + k), 0, 1, -1);
    check("drain count", cnt0, 0);
    bad = 0;
    repeat (100) begin
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
      tick();
    end
    check("drain no ninth frame", bad, 0);

    // Even parity, two stop bits: 0x07 has parity 1, frame 384 cycles
    d1 = 8'h07; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    check_frame(1, 8'h07, 1, 2, -1);
    check("parity idle after", busy1, 0);

    // CTS raised during data bit 3 does not truncate the frame
    c0 = 1'b1; v0 = 1'b1;
    d0 = 8'h3C; tick();
    d0 = 8'hC3; tick();
    v0 = 1'b0;
    c0 = 1'b0;
    tick();
    check_frame(0, 8'h3C, 0, 1, 4 * DIV + 10);
    check("cts hold busy", busy0, 0);
    check("cts hold tx", tx0, 1);
    bad = 0;
    repeat (50) begin
      if (busy0 !== 1'b0) bad++;
      tick();
    end
    check("cts held no frame", bad, 0);
    check("cts held count", cnt0, 1);
    c0 = 1'b0;
    tick();
    check_frame(0, 8'hC3, 0, 1, -1);

    // Reset during data bit 5 with three bytes still queued
    c0 = 1'b1; v0 = 1'b1;
    d0 = 8'h11; tick();
    d0 = 8'h22; tick();
    d0 = 8'h33; tick();
    d0 = 8'h44; tick();
    v0 = 1'b0;
    c0 = 1'b0;
    tick();
    check("pre-reset count", cnt0, 3);
    check("pre-reset start bit", tx0, 0);
    repeat (6 * DIV + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset tx", tx0, 1);
    check("mid reset count", cnt0, 0);
    check("mid reset busy", busy0, 0);
    check("mid reset ready", ready0, 1);
    bad = 0;
    repeat (400) begin
      if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
      tick();
    end
    check("post reset silent", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
